instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Front-end fetch block for the RISC-V core, sitting between the program counter and instruction memory on one side and decode on the other. It issues sequential word fetches to instruction memory with a valid/ready request channel and collects in-order responses into a small instruction queue. It presents the queue to decode with a valid/ready handshake and handles branch/jump redirects by flushing queued and in-flight instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: fetch address loaded on reset.
- DEPTH, 4: instruction queue entries; power of two, ≥2. Also bounds requests in flight.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  synchronous reset, active-high.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  32  fetch address, word-aligned.
- imem_rsp_valid  input  1  response valid, in request order, ≥1 cycle after acceptance, at most one per cycle, no backpressure.
- imem_rsp_data  input  32  fetched instruction.
- redirect_valid  input  1  branch/jump redirect, single-cycle pulse.
- redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0).
- dec_valid  output  1  queue head valid.
- dec_ready  input  1  decode consumes head.
- dec_instr  output  32  head instruction.
- dec_pc  output  32  address the head instruction was fetched from.
- fetch_pc  output  32  current fetch PC register (same value as imem_req_addr).

## Operation
- State: fetch_pc, outstanding counter (0..DEPTH), drop counter (0..DEPTH), queue of {instr, pc} with count, in-flight PC queue (DEPTH entries) pairing each accepted request's address with its response.
- FSM states: RUN, DRAIN.
  - RUN: imem_req_valid = !redirect_valid && (outstanding + count < DEPTH), using registered values only; pops in the same cycle do not free credit.
  - On request handshake: push fetch_pc to in-flight queue, outstanding += 1, fetch_pc += 4, wrapping modulo 2^32.
  - On response in RUN: pop in-flight queue, write {imem_rsp_data, popped pc} to instruction queue, outstanding -= 1. Simultaneous handshake and response: net outstanding unchanged.
  - Redirect, any state: fetch_pc ← {redirect_pc[31:2], 2'b00}; instruction and in-flight queues flushed; any response arriving this cycle is discarded; drop ← outstanding − (imem_rsp_valid ? 1 : 0); outstanding ← 0. Next state is DRAIN if the new drop value is nonzero, else RUN. imem_req_valid is low in the redirect cycle.
  - DRAIN: imem_req_valid = 0; each response is discarded and decrements drop; at drop = 1 with a response, go to RUN next cycle. A redirect in DRAIN recomputes drop as outstanding (0) plus the remaining drop minus any response arriving that cycle.
- Decode side: dec_valid = count ≠ 0; head pops on dec_valid && dec_ready; push and pop in the same cycle leave count unchanged. A pop in a redirect cycle is legal and the flush takes precedence.
- Overflow cannot occur by construction (credit rule). A response with outstanding = drop = 0 is a protocol violation; assert in simulation.
- imem_req_addr and imem_req_valid must be held stable while valid && !ready, unless a redirect occurs, in which case the request is withdrawn.

## Timing
- Reset values: fetch_pc = RESET_PC, imem_req_valid = 0 in the reset cycle, then 1 from the first cycle after rst deasserts; dec_valid = 0; dec_instr = 0; dec_pc = 0; state RUN; all counters 0.
- imem_rsp_data is registered into the queue, so dec_valid rises at the earliest 1 cycle after imem_rsp_valid.
- Redirect-to-new-request latency: 1 cycle if nothing is in flight; otherwise 1 cycle after the last dropped response.
- Throughput: 1 instruction/cycle sustained when memory latency + 1 ≤ DEPTH − 1 and decode is always ready.
- rst mid-operation clears everything. Instruction memory shares rst, so no pre-reset responses arrive.

## Test plan
- Reset, RESET_PC=0x100, memory latency 1, dec_ready=1 -> requests 0x100, 0x104, 0x108…; decode sees dec_pc 0x100, 0x104… with matching data, no gaps after warm-up.
- dec_ready=0 with 4 responses queued -> imem_req_valid low, count=4; dec_ready=1 for one cycle -> exactly one pop, one new request the next cycle.
- imem_req_ready held low 3 cycles -> imem_req_addr stable at 0x100, fetch_pc unchanged, no duplicate fetch.
- Two requests in flight (latency 3), redirect to 0x2003 -> both responses discarded, next request addr 0x2000, first dec_pc 0x2000.
- Redirect in the same cycle as a response and a decode pop -> response dropped, queue empty next cycle, drop = outstanding − 1.
- fetch_pc = 0xFFFF_FFFC accepted -> next request address 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch front end: sequential word fetches, in-flight PC tracking,
// instruction queue to decode, and redirect flush/drain handling.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] fetch_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LIM = CW'(DEPTH);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t state;
  state_t state_nx;

  logic [31:0]   pc_q;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [CW-1:0] credit;
  logic [CW-1:0] drop_nx;

  logic [31:0] q_instr [DEPTH];
  logic [31:0] q_pc    [DEPTH];
  logic [31:0] f_pc    [DEPTH];

  logic [AW-1:0] q_wr;
  logic [AW-1:0] q_rd;
  logic [AW-1:0] f_wr;
  logic [AW-1:0] f_rd;

  logic        req_fire;
  logic        push;
  logic        pop;
  logic [31:0] redir_pc;

  assign redir_pc = redirect_pc & ~32'h3;
  assign credit   = outstanding + count;
  assign drop_nx  = outstanding + drop - CW'(imem_rsp_valid);

  assign req_fire = imem_req_valid && imem_req_ready;
  assign push     = imem_rsp_valid && (state == RUN) && !redirect_valid;
  assign pop      = dec_valid && dec_ready;

  assign imem_req_addr = pc_q;
  assign fetch_pc      = pc_q;
  assign dec_valid     = (count != '0);
  assign dec_instr     = q_instr[q_rd];
  assign dec_pc        = q_pc[q_rd];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  // Next state: redirect decides between RUN/DRAIN, last drop returns
  always_comb begin
    state_nx = state;
    if (redirect_valid)
      state_nx = (drop_nx != '0) ? DRAIN : RUN;
    else if (state == DRAIN && imem_rsp_valid && drop == CW'(1))
      state_nx = RUN;
  end

  // Request valid from registered credit only, withdrawn on redirect
  always_comb begin
    imem_req_valid = 1'b0;
    unique case (1'b1)
      rst:            imem_req_valid = 1'b0;
      redirect_valid: imem_req_valid = 1'b0;
      default:
        imem_req_valid = (state == RUN) && (credit < LIM);
    endcase
  end

  // Fetch PC, outstanding and drop counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      pc_q        <= redir_pc;
      outstanding <= '0;
      drop        <= drop_nx;
    end else begin
      if (req_fire) pc_q <= pc_q + 32'd4;
      outstanding <= outstanding + CW'(req_fire) - CW'(push);
      if (state == DRAIN && imem_rsp_valid) drop <= drop - CW'(1);
    end
  end

  // In-flight PC queue pointers
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      f_wr <= '0;
      f_rd <= '0;
    end else begin
      if (req_fire) f_wr <= f_wr + 1'b1;
      if (push)     f_rd <= f_rd + 1'b1;
    end
  end

  // In-flight PC storage
  always_ff @(posedge clk) begin
    if (req_fire) f_pc[f_wr] <= pc_q;
  end

  // Instruction queue: push responses, pop to decode, flush on redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      q_wr  <= '0;
      q_rd  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      q_wr  <= '0;
      q_rd  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_instr[q_wr] <= imem_rsp_data;
        q_pc[q_wr]    <= f_pc[f_rd];
        q_wr          <= q_wr + 1'b1;
      end
      if (pop) q_rd <= q_rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // A response with nothing outstanding or pending drop is illegal
  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(imem_rsp_valid && outstanding == '0 && drop == '0));
  end

endmodule
